// File: rtl/y86_data_mem_responder.sv
// Y86-64 data-memory responder: one 8-byte access at a time over valid/ready,
// response after LATENCY cycles. Y86_DMEM_ALIGN_CHECK_EN also faults unaligned addresses.
module y86_data_mem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic [2:0]  rsp_stat
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Backing store has no reset; contents survive rst.
    logic [7:0]  mem [MEM_BYTES];

    logic [64:0]   end_addr;
    logic          bad;
    logic          accept;
    logic [AW-1:0] base;
    logic [63:0]   rd_word;

    always_comb begin
        end_addr = {1'b0, req_addr} + 65'd7;
        bad      = (end_addr >= 65'(MEM_BYTES));
`ifdef Y86_DMEM_ALIGN_CHECK_EN
        bad      = bad || (req_addr[2:0] != 3'd0);
`endif
        base     = req_addr[AW-1:0];
        accept   = (state == IDLE) && req_valid;
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 8; i++) begin
            rd_word[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept && req_write && !bad) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_stat  <= STAT_AOK;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        rsp_stat  <= bad ? STAT_ADR : STAT_AOK;
                        rsp_rdata <= (bad || req_write) ? 64'd0 : rd_word;
                        if (LATENCY <= 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    // Counter reaches zero on the edge that raises rsp_valid.
                    if (cnt <= 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_data_mem_responder.sv
// Scoreboard bench for y86_data_mem_responder: three instances with
// LATENCY 2, 4 and 1; a monitor pops expected responses at each handshake.
module tb_y86_data_mem_responder;

    localparam int N = 3;
    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] ADR = 3'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       req_write;
    logic [N-1:0][63:0] req_addr;
    logic [N-1:0][63:0] req_wdata;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_ready;
    logic [N-1:0][63:0] rsp_rdata;
    logic [N-1:0][2:0]  rsp_stat;

    for (genvar g = 0; g < N; g++) begin : g_dut
        y86_data_mem_responder #(
            .MEM_BYTES(1024),
            .LATENCY  ((g == 0) ? 2 : (g == 1) ? 4 : 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_write(req_write[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_stat (rsp_stat[g])
        );
    end

    typedef struct {
        logic [2:0]  st;
        logic [63:0] rd;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 4 : 1;
    endfunction

    function automatic void push(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t front(input int d);
        case (d)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(input int d);
        case (d)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    endfunction

    function automatic void tmo(input string nm);
        n_checks++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endfunction

    // Monitor samples 2 time units after the negedge, away from both edges.
    logic [N-1:0] pv = '0;
    always begin
        @(negedge clk);
        #2;
        for (int d = 0; d < N; d++) begin
            if (rsp_valid[d] && !pv[d] && qsize(d) != 0)
                chk($sformatf("latency[%0d]", d),
                    64'(cyc - front(d).acc), 64'(lat_of(d)));
            if (rsp_valid[d] && rsp_ready[d]) begin
                if (qsize(d) == 0) begin
                    n_checks++;
                    $display("FAIL rsp[%0d]: got a response, required none", d);
                end else begin
                    chk($sformatf("stat[%0d]", d), 64'(rsp_stat[d]),
                        64'(front(d).st));
                    chk($sformatf("rdata[%0d]", d), rsp_rdata[d], front(d).rd);
                    qpop(d);
                end
            end
        end
        pv = rsp_valid;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int d, input logic w, input logic [63:0] a,
                         input logic [63:0] wd, input logic [2:0] st,
                         input logic [63:0] rd);
        int n = 0;
        exp_t e;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            tmo($sformatf("req_ready[%0d]", d));
            return;
        end
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        e.st  = st;
        e.rd  = rd;
        e.acc = cyc;
        push(d, e);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (qsize(d) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (qsize(d) != 0) tmo($sformatf("drain[%0d]", d));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int acc;
        exp_t e;
        rst       = '1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '1;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            chk($sformatf("rst_ready[%0d]", d), 64'(req_ready[d]), 64'd1);
            chk($sformatf("rst_valid[%0d]", d), 64'(rsp_valid[d]), 64'd0);
            chk($sformatf("rst_rdata[%0d]", d), rsp_rdata[d], 64'd0);
            chk($sformatf("rst_stat[%0d]", d), 64'(rsp_stat[d]), 64'(AOK));
        end
        rst = '0;

        issue(0, 1'b1, 64'h10, 64'h1122334455667788, AOK, 64'd0);
        issue(0, 1'b0, 64'h10, 64'd0, AOK, 64'h1122334455667788);
        issue(0, 1'b1, 64'd1016, 64'h0102030405060708, AOK, 64'd0);
        issue(0, 1'b0, 64'd1016, 64'd0, AOK, 64'h0102030405060708);
        issue(0, 1'b0, 64'd1017, 64'd0, ADR, 64'd0);
        issue(0, 1'b1, 64'd1017, '1, ADR, 64'd0);
        issue(0, 1'b0, 64'd1016, 64'd0, AOK, 64'h0102030405060708);
        issue(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, ADR, 64'd0);
        issue(0, 1'b1, 64'h18, 64'h99AABBCCDDEEFF00, AOK, 64'd0);
`ifdef Y86_DMEM_ALIGN_CHECK_EN
        issue(0, 1'b0, 64'h11, 64'd0, ADR, 64'd0);
`else
        issue(0, 1'b0, 64'h11, 64'd0, AOK, 64'h0011223344556677);
`endif
        drain(0);

        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 64'h10, 64'd0, AOK, 64'h1122334455667788);
        n = 0;
        while (!rsp_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid[0]) tmo("bp_valid");
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(rsp_valid[0]), 64'd1);
            chk("bp_rdata", rsp_rdata[0], 64'h1122334455667788);
            chk("bp_stat", 64'(rsp_stat[0]), 64'(AOK));
            chk("bp_ready", 64'(req_ready[0]), 64'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(req_ready[0]), 64'd1);
        chk("bp_release_valid", 64'(rsp_valid[0]), 64'd0);

        issue(1, 1'b1, 64'h40, {8{8'hAA}}, AOK, 64'd0);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        q1.delete();
        chk("midrst_valid", 64'(rsp_valid[1]), 64'd0);
        chk("midrst_ready", 64'(req_ready[1]), 64'd1);
        chk("midrst_stat", 64'(rsp_stat[1]), 64'(AOK));
        issue(1, 1'b0, 64'h40, 64'd0, AOK, {8{8'hAA}});
        drain(1);

        issue(2, 1'b1, 64'h20, 64'hCAFEF00D12345678, AOK, 64'd0);
        drain(2);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b0;
        req_addr[2]  = 64'h20;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready[2]) begin
                e.st  = AOK;
                e.rd  = 64'hCAFEF00D12345678;
                e.acc = cyc;
                push(2, e);
                acc++;
            end
            @(negedge clk);
        end
        req_valid[2] = 1'b0;
        chk("lat1_accepts", 64'(acc), 64'd5);
        drain(2);

        for (int d = 0; d < N; d++)
            chk($sformatf("leftover[%0d]", d), 64'(qsize(d)), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
